// File: rtl/sram_word_arbiter.sv
// sram_word_arbiter: two-requester arbiter that turns 32-bit word accesses
// into four byte cycles on a 256x8 single-port SRAM macro.
module sram_word_arbiter #(
    parameter int RR = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_cyc,
    input  logic [5:0]  i_req0_adr,
    input  logic        i_req0_we,
    input  logic [3:0]  i_req0_sel,
    input  logic [31:0] i_req0_dat,
    output logic [31:0] o_req0_rdt,
    output logic        o_req0_ack,
    input  logic        i_req1_cyc,
    input  logic [5:0]  i_req1_adr,
    input  logic        i_req1_we,
    input  logic [3:0]  i_req1_sel,
    input  logic [31:0] i_req1_dat,
    output logic [31:0] o_req1_rdt,
    output logic        o_req1_ack,
    output logic        o_sram_cen,
    output logic        o_sram_gwen,
    output logic [7:0]  o_sram_wen,
    output logic [7:0]  o_sram_a,
    output logic [7:0]  o_sram_d,
    input  logic [7:0]  i_sram_q
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DRAIN, ST_ACK} state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_k, w_k_next;
    logic        r_gnt, w_gnt_next;
    logic        r_last_gnt, w_last_gnt_next;

    // Requester ports gathered into arrays so the datapath can index by port.
    logic [1:0]  w_cyc, w_we;
    logic [5:0]  w_adr [2];
    logic [3:0]  w_sel [2];
    logic [31:0] w_dat [2];

    assign w_cyc    = {i_req1_cyc, i_req0_cyc};
    assign w_we     = {i_req1_we, i_req0_we};
    assign w_adr[0] = i_req0_adr;
    assign w_adr[1] = i_req1_adr;
    assign w_sel[0] = i_req0_sel;
    assign w_sel[1] = i_req1_sel;
    assign w_dat[0] = i_req0_dat;
    assign w_dat[1] = i_req1_dat;

    // Control decided by the FSM each cycle.
    logic        w_drive_en;
    logic        w_drive_port;
    logic [1:0]  w_drive_byte;
    logic        w_cap_en;
    logic [1:0]  w_cap_byte;
    logic [1:0]  w_ack_next;

    // Registered macro drive and acks.
    logic        r_cen, w_cen_next;
    logic        r_gwen, w_gwen_next;
    logic [7:0]  r_wen, w_wen_next;
    logic [7:0]  r_a, w_a_next;
    logic [7:0]  r_d, w_d_next;
    logic [1:0]  r_ack;
    logic [31:0] r_rdt [2];

    // State register: arbitration state, byte counter, grant bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_k        <= 2'd0;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_k        <= w_k_next;
            r_gnt      <= w_gnt_next;
            r_last_gnt <= w_last_gnt_next;
        end
    end

    // Next state: arbitrate in IDLE, then walk four byte slots, drain, ack.
    always_comb begin
        w_state_next    = r_state;
        w_k_next        = r_k;
        w_gnt_next      = r_gnt;
        w_last_gnt_next = r_last_gnt;
        w_drive_en      = 1'b0;
        w_drive_port    = r_gnt;
        w_drive_byte    = 2'd0;
        w_cap_en        = 1'b0;
        w_cap_byte      = 2'd0;
        w_ack_next      = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_cyc != 2'b00) begin
                    if (w_cyc == 2'b01)      w_drive_port = 1'b0;
                    else if (w_cyc == 2'b10) w_drive_port = 1'b1;
                    else if (RR != 0)        w_drive_port = ~r_last_gnt;
                    else                     w_drive_port = 1'b0;
                    w_gnt_next      = w_drive_port;
                    w_last_gnt_next = w_drive_port;
                    w_state_next    = ST_ACCESS;
                    w_k_next        = 2'd0;
                    w_drive_en      = 1'b1;
                    w_drive_byte    = 2'd0;
                end
            end
            ST_ACCESS: begin
                // Macro output for the byte driven last cycle is valid now.
                w_cap_en   = (r_k != 2'd0) && !w_we[r_gnt];
                w_cap_byte = r_k - 2'd1;
                if (r_k == 2'd3) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_drive_en   = 1'b1;
                    w_drive_byte = r_k + 2'd1;
                    w_k_next     = r_k + 2'd1;
                end
            end
            ST_DRAIN: begin
                w_cap_en          = !w_we[r_gnt];
                w_cap_byte        = 2'd3;
                w_ack_next[r_gnt] = 1'b1;
                w_state_next      = ST_ACK;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_k_next     = 2'd0;
            end
        endcase
    end

    // Macro drive for the selected byte slot; idle values otherwise.
    always_comb begin
        w_cen_next  = 1'b1;
        w_gwen_next = 1'b1;
        w_wen_next  = 8'hFF;
        w_a_next    = 8'h00;
        w_d_next    = 8'h00;
        if (w_drive_en) begin
            w_a_next = {w_adr[w_drive_port], w_drive_byte};
            w_d_next = w_dat[w_drive_port][{w_drive_byte, 3'b000} +: 8];
            if (!w_we[w_drive_port]) begin
                w_cen_next = 1'b0;
            end else if (w_sel[w_drive_port][w_drive_byte]) begin
                w_cen_next  = 1'b0;
                w_gwen_next = 1'b0;
                w_wen_next  = 8'h00;
            end
        end
    end

    // Output registers for the macro pins and the ack pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cen  <= 1'b1;
            r_gwen <= 1'b1;
            r_wen  <= 8'hFF;
            r_a    <= 8'h00;
            r_d    <= 8'h00;
            r_ack  <= 2'b00;
        end else begin
            r_cen  <= w_cen_next;
            r_gwen <= w_gwen_next;
            r_wen  <= w_wen_next;
            r_a    <= w_a_next;
            r_d    <= w_d_next;
            r_ack  <= w_ack_next;
        end
    end

    // Per-port read-data registers; only the granted port's register changes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdt
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_rdt[gi] <= 32'h0;
                end else if (w_cap_en && (r_gnt == 1'(gi))) begin
                    r_rdt[gi][{w_cap_byte, 3'b000} +: 8] <= i_sram_q;
                end
            end
        end
    endgenerate

    assign o_sram_cen  = r_cen;
    assign o_sram_gwen = r_gwen;
    assign o_sram_wen  = r_wen;
    assign o_sram_a    = r_a;
    assign o_sram_d    = r_d;
    assign o_req0_ack  = r_ack[0];
    assign o_req1_ack  = r_ack[1];
    assign o_req0_rdt  = r_rdt[0];
    assign o_req1_rdt  = r_rdt[1];

endmodule

// File: tb/tb_sram_word_arbiter.sv
// Testbench for sram_word_arbiter: word-level memory model plus per-port
// scoreboards checked by a monitor on every ack.
module tb_sram_word_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cyc = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [5:0]  adr [2];
    logic [3:0]  sel [2];
    logic [31:0] dat [2];
    logic [31:0] rdt0, rdt1;
    logic        ack0, ack1;
    logic        cen, gwen;
    logic [7:0]  wen, sa, sd, sq;

    // Second instance with fixed priority; only its acks are observed.
    logic [1:0]  cyc2 = 2'b00;
    logic [31:0] rdt0_b, rdt1_b;
    logic        ack0_b, ack1_b, cen_b, gwen_b;
    logic [7:0]  wen_b, sa_b, sd_b;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdt [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    logic [7:0]  smem [256];
    logic        load_en = 1'b0;
    logic [7:0]  load_a = 8'h00;
    logic [7:0]  load_d = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    sram_word_arbiter #(.RR(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_cyc(cyc[0]), .i_req0_adr(adr[0]), .i_req0_we(we[0]),
        .i_req0_sel(sel[0]), .i_req0_dat(dat[0]),
        .o_req0_rdt(rdt0), .o_req0_ack(ack0),
        .i_req1_cyc(cyc[1]), .i_req1_adr(adr[1]), .i_req1_we(we[1]),
        .i_req1_sel(sel[1]), .i_req1_dat(dat[1]),
        .o_req1_rdt(rdt1), .o_req1_ack(ack1),
        .o_sram_cen(cen), .o_sram_gwen(gwen), .o_sram_wen(wen),
        .o_sram_a(sa), .o_sram_d(sd), .i_sram_q(sq)
    );

    sram_word_arbiter #(.RR(0)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0_cyc(cyc2[0]), .i_req0_adr(6'd0), .i_req0_we(1'b0),
        .i_req0_sel(4'h0), .i_req0_dat(32'h0),
        .o_req0_rdt(rdt0_b), .o_req0_ack(ack0_b),
        .i_req1_cyc(cyc2[1]), .i_req1_adr(6'd1), .i_req1_we(1'b0),
        .i_req1_sel(4'h0), .i_req1_dat(32'h0),
        .o_req1_rdt(rdt1_b), .o_req1_ack(ack1_b),
        .o_sram_cen(cen_b), .o_sram_gwen(gwen_b), .o_sram_wen(wen_b),
        .o_sram_a(sa_b), .o_sram_d(sd_b), .i_sram_q(8'h00)
    );

    // Behavioural 256x8 macro: registered read, per-bit active-low write.
    always @(posedge clk) begin
        if (load_en) begin
            smem[load_a] <= load_d;
        end else if (!cen) begin
            if (!gwen) begin
                for (int i = 0; i < 8; i++)
                    if (!wen[i]) smem[sa][i] <= sd[i];
            end else begin
                sq <= smem[sa];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p != 0) ? ack1 : ack0;
    endfunction

    // Word-level reference: apply the access and queue the rdt expected at ack.
    task automatic push_exp(input int p, input bit w, input logic [5:0] a,
                            input logic [3:0] s, input logic [31:0] dt);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = dt[8*b +: 8];
        end else begin
            ref_rdt[p] = ref_mem[a];
        end
        if (p == 0) exp_q0.push_back(ref_rdt[0]);
        else        exp_q1.push_back(ref_rdt[1]);
    endtask

    task automatic drive_port(input int p, input bit w, input logic [5:0] a,
                              input logic [3:0] s, input logic [31:0] dt);
        we[p]  = w;
        adr[p] = a;
        sel[p] = s;
        dat[p] = dt;
        cyc[p] = 1'b1;
    endtask

    // Monitor: every ack pops that port's scoreboard and checks rdt.
    always @(negedge clk) begin
        logic [31:0] e;
        if (ack0) begin
            if (exp_q0.size() == 0) begin
                chk("ack0_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                $display("txn port=0 rdt=%08h exp=%08h t=%0d", rdt0, e, cyc_n);
                chk("rdt0", rdt0, e);
            end
        end
        if (ack1) begin
            if (exp_q1.size() == 0) begin
                chk("ack1_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                $display("txn port=1 rdt=%08h exp=%08h t=%0d", rdt1, e, cyc_n);
                chk("rdt1", rdt1, e);
            end
        end
    end

    // Single uncontended transaction with cycle-exact checks of the macro drive.
    task automatic txn(input int p, input bit w, input logic [5:0] a,
                       input logic [3:0] s, input logic [31:0] dt, input bit drop);
        logic [1:0] eb;
        logic       cen_exp;
        push_exp(p, w, a, s, dt);
        @(negedge clk);
        drive_port(p, w, a, s, dt);
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (e < 4) begin
                eb = 2'(e);
                cen_exp = w && !s[eb];
                chk("slot_cen", cen, cen_exp);
                chk("slot_a", sa, {a, eb});
                chk("slot_d", sd, dt[8*e +: 8]);
                if (!cen_exp) begin
                    chk("slot_gwen", gwen, w ? 1'b0 : 1'b1);
                    chk("slot_wen", wen, w ? 8'h00 : 8'hFF);
                end
            end else if (e == 4) begin
                chk("drain_idle", {cen, gwen, wen, sa, sd}, {2'b11, 8'hFF, 16'h0});
                chk("drain_noack", get_ack(p), 1'b0);
            end else begin
                chk("ack_e5", get_ack(p), 1'b1);
            end
            if (drop && e == 1) cyc[p] = 1'b0;
        end
        cyc[p] = 1'b0;
        @(posedge clk); #1;
        chk("ack_drop_e6", get_ack(p), 1'b0);
    endtask

    // Both ports request continuously; grants must alternate 7 cycles apart.
    task automatic tie_test(input int n);
        int prev;
        int gp;
        bit got;
        for (int i = 0; i < n / 2; i++) begin
            push_exp(0, 1'b0, 6'd3, 4'h0, 32'h0);
            push_exp(1, 1'b0, 6'd40, 4'h0, 32'h0);
        end
        @(negedge clk);
        drive_port(0, 1'b0, 6'd3, 4'h0, 32'h0);
        drive_port(1, 1'b0, 6'd40, 4'h0, 32'h0);
        prev = 0;
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            gp = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(posedge clk); #1;
                if (ack0 || ack1) begin
                    got = 1'b1;
                    gp = ack1 ? 1 : 0;
                    if (i == 0) chk("tie_first_latency", t, 5);
                end
            end
            chk("tie_ack_seen", got, 1'b1);
            if (got) begin
                chk("tie_port", gp, i % 2);
                if (i > 0) chk("tie_gap", cyc_n - prev, 7);
                prev = cyc_n;
            end
            if (i == n - 1 || !got) cyc = 2'b00;
            if (!got) break;
        end
        repeat (2) @(posedge clk);
    endtask

    // Randomised requester confined to its own half of the word space.
    task automatic drv(input int p, input int n);
        bit w;
        logic [5:0] a;
        logic [3:0] s;
        logic [31:0] dt;
        bit got;
        for (int j = 0; j < n; j++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 31) + (p != 0 ? 32 : 0));
            s  = 4'($urandom);
            dt = $urandom;
            push_exp(p, w, a, s, dt);
            @(negedge clk);
            drive_port(p, w, a, s, dt);
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(posedge clk); #1;
                if (get_ack(p)) got = 1'b1;
            end
            chk("rnd_ack_seen", got, 1'b1);
            cyc[p] = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        bit drained;
        adr[0] = 6'd0; adr[1] = 6'd0;
        sel[0] = 4'h0; sel[1] = 4'h0;
        dat[0] = 32'h0; dat[1] = 32'h0;
        ref_rdt[0] = 32'h0; ref_rdt[1] = 32'h0;
        for (int w = 0; w < 64; w++) ref_mem[w] = $urandom;
        // Preload macro and model with the same random contents under reset.
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                load_en = 1'b1;
                load_a  = {6'(w), 2'(b)};
                load_d  = ref_mem[w][8*b +: 8];
            end
        end
        @(negedge clk);
        load_en = 1'b0;
        @(posedge clk); #1;
        chk("rst_drive", {cen, gwen, wen, sa, sd}, {2'b11, 8'hFF, 16'h0});
        chk("rst_acks", {ack1, ack0}, 2'b00);
        chk("rst_rdt0", rdt0, 32'h0);
        chk("rst_rdt1", rdt1, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        txn(0, 1'b1, 6'd5, 4'hF, 32'hA1B2C3D4, 1'b0);
        txn(0, 1'b0, 6'd5, 4'h0, 32'h0, 1'b0);
        chk("p0_readback", rdt0, 32'hA1B2C3D4);
        txn(1, 1'b1, 6'd5, 4'b0101, 32'h11223344, 1'b0);
        txn(1, 1'b0, 6'd5, 4'h0, 32'h0, 1'b0);
        chk("p1_partial_readback", rdt1, 32'hA122C344);
        chk("p0_untouched", rdt0, 32'hA1B2C3D4);

        txn(0, 1'b1, 6'd9, 4'hF, 32'h5EED_F00D, 1'b1);
        txn(0, 1'b0, 6'd9, 4'h0, 32'h0, 1'b0);

        // Reset at E3 of a port-0 read: abandoned with no ack.
        @(negedge clk);
        drive_port(0, 1'b0, 6'd12, 4'h0, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_drive", {cen, gwen, wen, sa, sd}, {2'b11, 8'hFF, 16'h0});
        chk("midrst_acks", {ack1, ack0}, 2'b00);
        chk("midrst_rdt0", rdt0, 32'h0);
        chk("midrst_rdt1", rdt1, 32'h0);
        ref_rdt[0] = 32'h0;
        ref_rdt[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        cyc[0] = 1'b0;
        n0 = 0;
        repeat (8) begin @(posedge clk); #1; if (ack0 || ack1) n0++; end
        chk("midrst_no_ack", n0, 0);

        tie_test(6);

        fork
            drv(0, 20);
            drv(1, 20);
        join

        drained = 1'b0;
        for (int t = 0; t < 20 && !drained; t++) begin
            @(posedge clk); #1;
            drained = (exp_q0.size() == 0) && (exp_q1.size() == 0);
        end
        chk("scoreboard_drained", drained, 1'b1);

        // Fixed-priority instance: port 0 wins every tie.
        @(negedge clk);
        cyc2 = 2'b11;
        n0 = 0;
        n1 = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (ack0_b) n0++;
            if (ack1_b) n1++;
        end
        cyc2 = 2'b00;
        chk("fp_port1_acks", n1, 0);
        chk("fp_port0_acks", n0, 8);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
